// File: rtl/histo_pkg.sv
// rtl/histo_pkg.sv - shared constants and sequencer state encoding for the histogram readout path
// Purpose: constants shared by the readout sequencer, its stream register and the framer debug decode.
// Contents: NUM_BINS, BIN_W, COUNT_W, STREAM_W, FRAME_W, READ_LAT, HDR_TAG, seq_state_e.
package histo_pkg;

    localparam int NUM_BINS = 1024;
    localparam int BIN_W    = 10;
    localparam int COUNT_W  = 24;
    localparam int STREAM_W = 32;
    localparam int FRAME_W  = 12;
    localparam int READ_LAT = 3;
    localparam logic [7:0] HDR_TAG = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_SETBIN = 3'd2,
        ST_WAIT   = 3'd3,
        ST_SEND   = 3'd4,
        ST_TRL    = 3'd5
    } seq_state_e;

endpackage

// File: rtl/histo_stream_reg.sv
// rtl/histo_stream_reg.sv - single-entry valid/ready output register for the readout stream
// Purpose: holds one outgoing word stable until the downstream accepts it.
// Ports: clk, rst (async active-high); load_i/load_data_i/load_last_i from the sequencer;
//        m_ready_i from downstream; m_valid_o/m_data_o/m_last_o to downstream;
//        accept_o pulses on the cycle a word transfers.
module histo_stream_reg
    import histo_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic [STREAM_W-1:0] load_data_i,
    input  logic                load_last_i,
    input  logic                m_ready_i,
    output logic                m_valid_o,
    output logic [STREAM_W-1:0] m_data_o,
    output logic                m_last_o,
    output logic                accept_o
);

    logic                m_valid_q, m_valid_d;
    logic [STREAM_W-1:0] m_data_q,  m_data_d;
    logic                m_last_q,  m_last_d;

    assign accept_o = m_valid_q & m_ready_i;

    // A load may coincide with the accept of the previous word; the new word wins.
    // Data is left untouched after acceptance so the bus never glitches.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        if (load_i) begin
            m_valid_d = 1'b1;
            m_data_d  = load_data_i;
            m_last_d  = load_last_i;
        end else if (accept_o) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_valid_o = m_valid_q;
    assign m_data_o  = m_data_q;
    assign m_last_o  = m_last_q;

endmodule

// File: rtl/histo_readout_seq.sv
// rtl/histo_readout_seq.sv - frame-end histogram sweep and header/count/checksum stream sequencer
// Purpose: at each frame end, switch the histogram to read mode, sweep every bin and stream
//          header, NUM_BINS count words and a checksum trailer, then return to accumulate mode.
// Ports: clk, rst (async active-high), enable, frame_valid, frame_number[11:0] (sensor side);
//        histo_rw, histo_bin[9:0], histo_data[23:0] (histogram side);
//        m_valid, m_ready, m_data[31:0], m_last (stream side); busy, overrun (status).
module histo_readout_seq
    import histo_pkg::*;
#(
    parameter int         NUM_BINS_P = NUM_BINS,
    parameter int         READ_LAT_P = READ_LAT,
    parameter logic [7:0] HDR_TAG_P  = HDR_TAG
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                frame_valid,
    input  logic [FRAME_W-1:0]  frame_number,
    output logic                histo_rw,
    output logic [BIN_W-1:0]    histo_bin,
    input  logic [COUNT_W-1:0]  histo_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [STREAM_W-1:0] m_data,
    output logic                m_last,
    output logic                busy,
    output logic                overrun
);

    localparam int WAIT_W = (READ_LAT_P < 2) ? 1 : $clog2(READ_LAT_P);
    localparam logic [BIN_W-1:0]  LAST_BIN = BIN_W'(NUM_BINS_P - 1);
    localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(READ_LAT_P - 1);

    seq_state_e          state_q, state_d;
    logic                fv_q;
    logic                rw_q, rw_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [STREAM_W-1:0] checksum_q, checksum_d;
    logic                overrun_q, overrun_d;

    logic                load;
    logic [STREAM_W-1:0] load_data;
    logic                load_last;
    logic                accept;
    logic                frame_end;

    assign frame_end = fv_q & ~frame_valid;

    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        bin_d      = bin_q;
        wait_d     = wait_q;
        checksum_d = checksum_q;
        load       = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        // Any new frame starting while the histogram is still in read mode loses counts.
        overrun_d  = overrun_q | (frame_valid & ~fv_q & ~rw_q);

        unique case (state_q)
            ST_IDLE: begin
                rw_d  = 1'b1;
                bin_d = LAST_BIN;
                if (frame_end && enable) begin
                    checksum_d = '0;
                    rw_d       = 1'b0;
                    load       = 1'b1;
                    load_data  = {HDR_TAG_P, 12'h000, frame_number};
                    state_d    = ST_HDR;
                end
            end
            ST_HDR: begin
                if (accept) begin
                    // Bin was parked at the last index, so moving to 0 is a real change.
                    bin_d   = '0;
                    state_d = ST_SETBIN;
                end
            end
            ST_SETBIN: begin
                wait_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q == WAIT_END) begin
                    load      = 1'b1;
                    load_data = {{(STREAM_W-COUNT_W){1'b0}}, histo_data};
                    state_d   = ST_SEND;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (accept) begin
                    // The stream register still holds the captured count.
                    checksum_d = checksum_q + m_data;
                    if (bin_q == LAST_BIN) begin
                        load      = 1'b1;
                        load_data = checksum_d;
                        load_last = 1'b1;
                        state_d   = ST_TRL;
                    end else begin
                        bin_d   = bin_q + 1'b1;
                        state_d = ST_SETBIN;
                    end
                end
            end
            ST_TRL: begin
                if (accept) begin
                    rw_d    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                rw_d    = 1'b1;
                bin_d   = LAST_BIN;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fv_q       <= 1'b0;
            rw_q       <= 1'b1;
            bin_q      <= LAST_BIN;
            wait_q     <= '0;
            checksum_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fv_q       <= frame_valid;
            rw_q       <= rw_d;
            bin_q      <= bin_d;
            wait_q     <= wait_d;
            checksum_q <= checksum_d;
            overrun_q  <= overrun_d;
        end
    end

    histo_stream_reg u_stream_reg (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .load_data_i (load_data),
        .load_last_i (load_last),
        .m_ready_i   (m_ready),
        .m_valid_o   (m_valid),
        .m_data_o    (m_data),
        .m_last_o    (m_last),
        .accept_o    (accept)
    );

    assign histo_rw  = rw_q;
    assign histo_bin = bin_q;
    assign busy      = (state_q != ST_IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_histo_readout_seq.sv
// tb/tb_histo_readout_seq.sv - scoreboard bench for the histogram readout sequencer
module tb_histo_readout_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        frame_valid;
    logic [11:0] frame_number;
    logic        histo_rw;
    logic [9:0]  histo_bin;
    logic [23:0] histo_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic        busy;
    logic        overrun;

    int total  = 0;
    int passed = 0;
    int rmode  = 0;
    int cyc    = 0;

    logic [32:0] exp_q[$];
    logic [23:0] mem[1024];
    logic [23:0] p1, p2, p3;

    always #5 clk = ~clk;

    histo_readout_seq dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .frame_valid  (frame_valid),
        .frame_number (frame_number),
        .histo_rw     (histo_rw),
        .histo_bin    (histo_bin),
        .histo_data   (histo_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .busy         (busy),
        .overrun      (overrun)
    );

    // Histogram read path: three cycles from bin change to valid count.
    always @(posedge clk) begin
        p1 <= mem[histo_bin];
        p2 <= p1;
        p3 <= p2;
    end
    assign histo_data = p3;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic push_frame(input logic [11:0] fn);
        logic [31:0] sum;
        sum = 32'h0;
        exp_q.push_back({1'b0, 8'hA5, 12'h000, fn});
        for (int i = 0; i < 1024; i++) begin
            exp_q.push_back({1'b0, 8'h00, mem[i]});
            sum = sum + {8'h00, mem[i]};
        end
        exp_q.push_back({1'b1, sum});
    endtask

    task automatic frame_pulse(input logic [11:0] fn, input logic expect_out);
        @(posedge clk); #1;
        frame_number = fn;
        frame_valid  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        frame_valid = 1'b0;
        if (expect_out) push_frame(fn);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        check1({name, "_complete"}, (exp_q.size() == 0) && !busy, 1'b1);
        check1({name, "_histo_rw"}, histo_rw, 1'b1);
        check({name, "_histo_bin"}, {23'h0, histo_bin}, 33'h3FF);
    endtask

    task automatic wait_bin(input string name, input logic [9:0] b);
        int n;
        n = 0;
        while (histo_bin != b && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_reach_bin"}, {23'h0, histo_bin}, {23'h0, b});
    endtask

    // Downstream ready pattern.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            cyc++;
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 3 == 0);
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each transfer and checks stability during stalls.
    initial begin
        logic        hold;
        logic [32:0] held;
        logic [32:0] e;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check1("stall_valid", m_valid, 1'b1);
                    check("stall_word", {m_last, m_data}, held);
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_word: got %h expected none", {m_last, m_data});
                    end else begin
                        e = exp_q.pop_front();
                        check("stream_word", {m_last, m_data}, e);
                    end
                    hold = 1'b0;
                end else if (m_valid) begin
                    hold = 1'b1;
                    held = {m_last, m_data};
                end else begin
                    hold = 1'b0;
                end
            end
        end
    end

    initial begin
        rst          = 1'b1;
        enable       = 1'b1;
        frame_valid  = 1'b0;
        frame_number = 12'h000;
        for (int i = 0; i < 1024; i++) mem[i] = 24'(i);

        repeat (3) @(posedge clk);
        #1;
        check1("rst_histo_rw", histo_rw, 1'b1);
        check("rst_histo_bin", {23'h0, histo_bin}, 33'h3FF);
        check1("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", {1'b0, m_data}, 33'h0);
        check1("rst_m_last", m_last, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_overrun", overrun, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Ramp histogram, ready always high.
        frame_pulse(12'h123, 1'b1);
        wait_done("ramp");
        check1("ramp_overrun", overrun, 1'b0);

        // Same frame, ready high one cycle in three.
        rmode = 1;
        frame_pulse(12'h124, 1'b1);
        wait_done("stall");
        rmode = 0;

        // Saturated bins: checksum wraps modulo 2^32.
        for (int i = 0; i < 1024; i++) mem[i] = 24'hFFFFFF;
        frame_pulse(12'h200, 1'b1);
        wait_done("sat");

        // 256 saturated bins plus 0x100 wraps to zero, plus 0xFF leaves 0xFF.
        for (int i = 0; i < 1024; i++) mem[i] = (i < 256) ? 24'hFFFFFF : 24'h0;
        mem[512] = 24'h000100;
        mem[700] = 24'h0000FF;
        frame_pulse(12'h201, 1'b1);
        wait_done("wrap");

        // New frame during the sweep: overrun set, the frame end it brings is ignored.
        for (int i = 0; i < 1024; i++) mem[i] = 24'(i);
        frame_pulse(12'h300, 1'b1);
        wait_bin("ovr", 10'd500);
        frame_pulse(12'h7FF, 1'b0);
        @(negedge clk);
        check1("ovr_set", overrun, 1'b1);
        check1("ovr_still_busy", busy, 1'b1);
        wait_done("ovr");
        repeat (20) @(negedge clk);
        check1("ovr_sticky", overrun, 1'b1);
        check1("ovr_no_second_frame", busy, 1'b0);

        // Reset while stalled at bin 300.
        frame_pulse(12'h301, 1'b1);
        wait_bin("rstmid", 10'd300);
        m_ready = 1'b0;
        rmode   = 2;
        repeat (8) @(negedge clk);
        check1("rstmid_stalled", m_valid, 1'b1);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check1("rstmid_m_valid", m_valid, 1'b0);
        check1("rstmid_histo_rw", histo_rw, 1'b1);
        check("rstmid_histo_bin", {23'h0, histo_bin}, 33'h3FF);
        check1("rstmid_busy", busy, 1'b0);
        check1("rstmid_overrun", overrun, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        rmode = 0;
        frame_pulse(12'h302, 1'b1);
        wait_done("after_rst");

        // Frame end with enable low produces nothing.
        enable = 1'b0;
        frame_pulse(12'h400, 1'b0);
        repeat (20) @(negedge clk);
        check1("dis_busy", busy, 1'b0);
        check1("dis_histo_rw", histo_rw, 1'b1);
        check1("dis_m_valid", m_valid, 1'b0);
        enable = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
